hamming_regfile: RTL and testbench



---
 rtl/hamming_regfile.sv | 221 ++++++++++++++++++++++
 tb/tb_hamming_regfile.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_regfile.sv
// SEC-DED protected register file: one write port, one registered read port,
// and a background scrubber that repairs single-bit errors in valid entries.
// Stored word layout: bit 0 = overall parity, bits 1..N = Hamming positions
// (check bits at powers of two, data bits in the remaining positions).

package hamming_regfile_pkg;
  // Number of Hamming check bits needed to cover d data bits.
  function automatic int ecc_bits(input int d);
    int r;
    r = 1;
    while ((1 << r) < d + r + 1) r = r + 1;
    return r;
  endfunction
endpackage

module hamming_regfile
  import hamming_regfile_pkg::*;
#(
  parameter int p_dataSize          = 8,
  parameter int p_depth             = 8,
  parameter int p_zeroWordDetection = 0,
  parameter int p_scrubInterval     = 64,
  parameter int p_cntWidth          = 8,
  localparam int R = ecc_bits(p_dataSize),
  localparam int N = p_dataSize + R,
  localparam int W = N + 1,
  localparam int A = $clog2(p_depth)
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WE,
  input  logic [A-1:0]          wrAddr,
  input  logic [p_dataSize-1:0] inputData,
  input  logic [W-1:0]          injMask,
  input  logic                  RE,
  input  logic [A-1:0]          rdAddr,
  output logic [p_dataSize-1:0] outputData,
  output logic                  rdValid,
  output logic                  correctableError,
  output logic                  uncorrectableError,
  input  logic                  scrubEn,
  output logic                  scrubBusy,
  output logic [p_cntWidth-1:0] corrCount,
  output logic [p_cntWidth-1:0] uncorrCount,
  output logic [p_depth-1:0]    uncorrFlags,
  input  logic                  clrCounters
);

  localparam int CW = (p_scrubInterval > 1) ? $clog2(p_scrubInterval) : 1;

  typedef struct packed {
    logic [W-1:0] fixed;  // corrected word (raw word when uncorrectable)
    logic         ce;
    logic         ue;
  } dec_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK} state_t;

  function automatic logic [W-1:0] encode(input logic [p_dataSize-1:0] d);
    logic [W-1:0] w;
    logic [R-1:0] s;
    int k;
    w = '0; s = '0; k = 0;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        w[p] = d[k];
        if (d[k]) s = s ^ R'(p);
        k++;
      end
    // Check bit i equals syndrome bit i, which drives the syndrome to zero.
    for (int i = 0; i < R; i++) w[1 << i] = s[i];
    w[0] = ^w[N:1];
    return w;
  endfunction

  function automatic dec_t decode(input logic [W-1:0] w);
    dec_t r;
    logic [R-1:0] s;
    int si;
    s = '0;
    for (int p = 1; p <= N; p++)
      if (w[p]) s = s ^ R'(p);
    si = int'(s);
    r.fixed = w; r.ce = 1'b0; r.ue = 1'b0;
    if (p_zeroWordDetection != 0 && w == '0) r.ue = 1'b1;
    else if (^w) begin
      // Odd overall parity: single flip at the syndrome position (0 = parity bit).
      if (si <= N) begin
        r.fixed[si] = ~w[si];
        r.ce = 1'b1;
      end else r.ue = 1'b1;
    end else if (s != '0) r.ue = 1'b1;
    return r;
  endfunction

  function automatic logic [p_dataSize-1:0] extract(input logic [W-1:0] w);
    logic [p_dataSize-1:0] d;
    int k;
    d = '0; k = 0;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        d[k] = w[p];
        k++;
      end
    return d;
  endfunction

  logic [W-1:0]          r_mem [p_depth];
  logic [p_depth-1:0]    r_valid;
  logic [p_depth-1:0]    r_flags;
  logic [p_cntWidth-1:0] r_corrCnt, r_uncorrCnt;
  state_t                r_state;
  logic [CW-1:0]         r_intCnt;
  logic [A-1:0]          r_scrubPtr;

  dec_t w_rdDec, w_scDec;
  logic w_rdVal, w_scVal, w_rdWb, w_scDo, w_scWb, w_incCorr, w_incUncorr;

  assign w_rdDec     = decode(r_mem[rdAddr]);
  assign w_scDec     = decode(r_mem[r_scrubPtr]);
  assign w_rdVal     = RE && r_valid[rdAddr];
  assign w_scVal     = r_valid[r_scrubPtr];
  // External write to the same entry supersedes the read's repair.
  assign w_rdWb      = w_rdVal && w_rdDec.ce && !(WE && wrAddr == rdAddr);
  // Scrub step only executes in a cycle free of port traffic.
  assign w_scDo      = (r_state == S_CHECK) && scrubEn && !WE && !RE;
  assign w_scWb      = w_scDo && w_scVal && w_scDec.ce;
  assign w_incCorr   = (w_rdVal && w_rdDec.ce) || (w_scDo && w_scVal && w_scDec.ce);
  assign w_incUncorr = (w_rdVal && w_rdDec.ue) || (w_scDo && w_scVal && w_scDec.ue);

  // Storage array: external write plus read/scrub repairs (not reset).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (WE)     r_mem[wrAddr]     <= encode(inputData) ^ injMask;
      if (w_rdWb) r_mem[rdAddr]     <= w_rdDec.fixed;
      if (w_scWb) r_mem[r_scrubPtr] <= w_scDec.fixed;
    end
  end

  // Valid bits and sticky flags; a write clears the flag it lands on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_flags <= '0;
    end else begin
      if (w_rdVal && w_rdDec.ue)          r_flags[rdAddr]     <= 1'b1;
      if (w_scDo && w_scVal && w_scDec.ue) r_flags[r_scrubPtr] <= 1'b1;
      if (WE) begin
        r_valid[wrAddr] <= 1'b1;
        r_flags[wrAddr] <= 1'b0;
      end
    end
  end

  // Registered read result and its qualifying pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdValid            <= 1'b0;
      outputData         <= '0;
      correctableError   <= 1'b0;
      uncorrectableError <= 1'b0;
    end else begin
      rdValid            <= RE;
      correctableError   <= w_rdVal && w_rdDec.ce;
      uncorrectableError <= w_rdVal && w_rdDec.ue;
      if (RE) outputData <= r_valid[rdAddr] ? extract(w_rdDec.fixed) : '0;
    end
  end

  // Saturating event counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_corrCnt   <= '0;
      r_uncorrCnt <= '0;
    end else if (clrCounters) begin
      r_corrCnt   <= '0;
      r_uncorrCnt <= '0;
    end else begin
      if (w_incCorr && r_corrCnt != '1)     r_corrCnt   <= r_corrCnt + 1'b1;
      if (w_incUncorr && r_uncorrCnt != '1) r_uncorrCnt <= r_uncorrCnt + 1'b1;
    end
  end

  // Scrubber: wait the interval, check one entry when the ports are idle, advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_intCnt   <= '0;
      r_scrubPtr <= '0;
    end else if (!scrubEn) begin
      r_state  <= S_IDLE;
      r_intCnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state  <= S_WAIT;
          r_intCnt <= '0;
        end
        S_WAIT: begin
          if (r_intCnt == CW'(p_scrubInterval - 1)) begin
            r_state  <= S_CHECK;
            r_intCnt <= '0;
          end else r_intCnt <= r_intCnt + 1'b1;
        end
        S_CHECK: begin
          if (!WE && !RE) begin
            r_scrubPtr <= (r_scrubPtr == A'(p_depth - 1)) ? '0 : r_scrubPtr + 1'b1;
            r_state    <= S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign scrubBusy   = (r_state == S_CHECK);
  assign corrCount   = r_corrCnt;
  assign uncorrCount = r_uncorrCnt;
  assign uncorrFlags = r_flags;

endmodule

// File: tb/tb_hamming_regfile.sv
// Bench for hamming_regfile: directed vector table plus a randomized scrubber run
// checked against a per-entry data model.
module tb_hamming_regfile;
  localparam int DW = 8, DEP = 8, AW = 3, W = 13, CNT = 2;

  logic clk = 1'b0;
  logic rst, WE, RE, scrubEn, clrCounters;
  logic [AW-1:0] wrAddr, rdAddr;
  logic [DW-1:0] inputData, outputData;
  logic [W-1:0] injMask;
  logic rdValid, correctableError, uncorrectableError, scrubBusy;
  logic [CNT-1:0] corrCount, uncorrCount;
  logic [DEP-1:0] uncorrFlags;

  always #5 clk = ~clk;

  hamming_regfile #(.p_dataSize(DW), .p_depth(DEP), .p_zeroWordDetection(0),
                    .p_scrubInterval(4), .p_cntWidth(CNT)) dut (
    .clk(clk), .rst(rst), .WE(WE), .wrAddr(wrAddr), .inputData(inputData),
    .injMask(injMask), .RE(RE), .rdAddr(rdAddr), .outputData(outputData),
    .rdValid(rdValid), .correctableError(correctableError),
    .uncorrectableError(uncorrectableError), .scrubEn(scrubEn),
    .scrubBusy(scrubBusy), .corrCount(corrCount), .uncorrCount(uncorrCount),
    .uncorrFlags(uncorrFlags), .clrCounters(clrCounters));

  int total = 0, bad = 0;

  typedef struct {
    bit we; logic [AW-1:0] wa; logic [DW-1:0] d; logic [W-1:0] m;
    bit re; logic [AW-1:0] ra; bit clr;
    bit chkd; logic [DW-1:0] ed; bit ece, eue;
    logic [CNT-1:0] ecc, euc; logic [DEP-1:0] efl;
  } vec_t;
  vec_t tbl[$];

  logic [DW-1:0] mdata [DEP];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic cyc(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                     input logic [W-1:0] m, input bit re, input logic [AW-1:0] ra,
                     input bit clr);
    @(negedge clk);
    WE = we; wrAddr = wa; inputData = d; injMask = m;
    RE = re; rdAddr = ra; clrCounters = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                      input logic [W-1:0] m, input bit re, input logic [AW-1:0] ra,
                      input bit clr, input bit chkd, input logic [DW-1:0] ed,
                      input bit ece, input bit eue, input int ecc, input int euc,
                      input logic [DEP-1:0] efl);
    vec_t v;
    v.we = we; v.wa = wa; v.d = d; v.m = m; v.re = re; v.ra = ra; v.clr = clr;
    v.chkd = chkd; v.ed = ed; v.ece = ece; v.eue = eue;
    v.ecc = CNT'(ecc); v.euc = CNT'(euc); v.efl = efl;
    tbl.push_back(v);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [W-1:0] m,
                    input int cc, input int uc, input logic [DEP-1:0] fl);
    addv(1, a, d, m, 0, 0, 0, 0, 0, 0, 0, cc, uc, fl);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] ed, input bit ce,
                    input int cc, input int uc, input logic [DEP-1:0] fl);
    addv(0, 0, 0, 0, 1, a, 0, 1, ed, ce, 0, cc, uc, fl);
  endtask

  task automatic rdu(input logic [AW-1:0] a, input int cc, input int uc,
                     input logic [DEP-1:0] fl);
    addv(0, 0, 0, 0, 1, a, 0, 0, 0, 0, 1, cc, uc, fl);
  endtask

  initial begin
    logic [W-1:0] mm;
    logic [DW-1:0] d;
    logic [AW-1:0] ra;
    logic [AW-1:0] cl [6];
    bit re, done, anyBusy;
    int prevCc, t1, t2;

    rst = 1'b1; WE = 0; RE = 0; scrubEn = 0; clrCounters = 0;
    wrAddr = 0; rdAddr = 0; inputData = 0; injMask = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_vld", rdValid, 0);
    chk("rst_data", outputData, 0);
    chk("rst_ce", correctableError, 0);
    chk("rst_ue", uncorrectableError, 0);
    chk("rst_cc", corrCount, 0);
    chk("rst_uc", uncorrCount, 0);
    chk("rst_flags", uncorrFlags, 0);
    chk("rst_busy", scrubBusy, 0);

    // ---------------- directed vector table ----------------
    for (int a = 0; a < DEP; a++) rd(AW'(a), 8'h00, 0, 0, 0, 8'h00);
    wr(3, 8'hA5, 13'h0, 0, 0, 8'h00);
    rd(3, 8'hA5, 0, 0, 0, 8'h00);
    wr(5, 8'h3C, 13'h4, 0, 0, 8'h00);
    rd(5, 8'h3C, 1, 1, 0, 8'h00);
    rd(5, 8'h3C, 0, 1, 0, 8'h00);
    wr(1, 8'h5A, 13'h18, 1, 0, 8'h00);
    rdu(1, 1, 1, 8'h02);
    rdu(1, 1, 2, 8'h02);
    wr(1, 8'h77, 13'h0, 1, 2, 8'h00);
    rd(1, 8'h77, 0, 1, 2, 8'h00);
    addv(1, 3, 8'h11, 13'h0, 1, 3, 0, 1, 8'hA5, 0, 0, 1, 2, 8'h00);
    rd(3, 8'h11, 0, 1, 2, 8'h00);
    wr(5, 8'h3C, 13'h1, 1, 2, 8'h00);
    addv(1, 5, 8'h22, 13'h0, 1, 5, 0, 1, 8'h3C, 1, 0, 2, 2, 8'h00);
    rd(5, 8'h22, 0, 2, 2, 8'h00);
    wr(6, 8'h99, 13'h100, 2, 2, 8'h00);
    addv(1, 7, 8'h42, 13'h0, 1, 6, 0, 1, 8'h99, 1, 0, 3, 2, 8'h00);
    rd(6, 8'h99, 0, 3, 2, 8'h00);
    rd(7, 8'h42, 0, 3, 2, 8'h00);
    addv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      mm = '0; mm[i+1] = 1'b1;
      wr(2, DW'(8'h10 + i), mm, (i < 3) ? i : 3, 0, 8'h00);
      rd(2, DW'(8'h10 + i), 1, (i + 1 < 3) ? i + 1 : 3, 0, 8'h00);
    end
    wr(2, 8'hF0, 13'h1000, 3, 0, 8'h00);
    addv(0, 0, 0, 0, 1, 2, 1, 1, 8'hF0, 1, 0, 0, 0, 8'h00);

    foreach (tbl[i]) begin
      cyc(tbl[i].we, tbl[i].wa, tbl[i].d, tbl[i].m, tbl[i].re, tbl[i].ra, tbl[i].clr);
      chk($sformatf("v%0d_vld", i), rdValid, tbl[i].re);
      if (tbl[i].re) begin
        if (tbl[i].chkd) chk($sformatf("v%0d_data", i), outputData, tbl[i].ed);
        chk($sformatf("v%0d_ce", i), correctableError, tbl[i].ece);
        chk($sformatf("v%0d_ue", i), uncorrectableError, tbl[i].eue);
      end
      chk($sformatf("v%0d_cc", i), corrCount, tbl[i].ecc);
      chk($sformatf("v%0d_uc", i), uncorrCount, tbl[i].euc);
      chk($sformatf("v%0d_flags", i), uncorrFlags, tbl[i].efl);
    end

    // ---------------- scrubber with random reads ----------------
    for (int a = 0; a < DEP; a++) begin
      d = DW'($urandom);
      mdata[a] = d;
      mm = '0;
      if (a == 0 || a == 6) mm[$urandom_range(0, W-1)] = 1'b1;
      cyc(1, AW'(a), d, mm, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("scr_clr", corrCount, 0);

    scrubEn = 1'b1;
    t1 = -1; t2 = -1;
    for (int c = 0; c < 20; c++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      if (scrubBusy) begin
        if (t1 < 0) t1 = c;
        else if (t2 < 0) t2 = c;
      end
    end
    chk("scr_period", t2 - t1, 5);

    cl[0] = 1; cl[1] = 2; cl[2] = 3; cl[3] = 4; cl[4] = 5; cl[5] = 7;
    prevCc = int'(corrCount);
    done = (corrCount == 2);
    for (int c = 0; c < 1000 && !done; c++) begin
      re = 1'($urandom % 2);
      ra = cl[$urandom % 6];
      cyc(0, 0, 0, 0, re, ra, 0);
      if (re) begin
        chk("rnd_vld", rdValid, 1);
        chk("rnd_data", outputData, mdata[ra]);
        chk("rnd_ce", correctableError, 0);
      end
      if (int'(corrCount) != prevCc) chk("scr_stall", re, 0);
      prevCc = int'(corrCount);
      if (corrCount == 2) done = 1;
    end
    chk("scr_fix2", corrCount, 2);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("scr_a0_data", outputData, mdata[0]);
    chk("scr_a0_ce", correctableError, 0);
    cyc(0, 0, 0, 0, 1, 6, 0);
    chk("scr_a6_data", outputData, mdata[6]);
    chk("scr_a6_ce", correctableError, 0);

    // A fresh fault at entry 0 is only reached again after the pointer wraps.
    d = DW'($urandom);
    mdata[0] = d;
    mm = '0; mm[$urandom_range(0, W-1)] = 1'b1;
    cyc(1, 0, d, mm, 0, 0, 0);
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      if (corrCount == 3) done = 1;
    end
    chk("scr_wrap", corrCount, 3);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("scr_wrap_data", outputData, mdata[0]);
    chk("scr_wrap_ce", correctableError, 0);

    scrubEn = 1'b0;
    anyBusy = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      if (scrubBusy) anyBusy = 1;
    end
    chk("scr_off_busy", anyBusy, 0);

    // ---------------- async reset mid-read ----------------
    scrubEn = 1'b1;
    cyc(0, 0, 0, 0, 1, 3, 0);
    chk("ar_vld_before", rdValid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_vld", rdValid, 0);
    chk("ar_busy", scrubBusy, 0);
    chk("ar_cc", corrCount, 0);
    chk("ar_flags", uncorrFlags, 0);
    @(negedge clk);
    rst = 1'b0; scrubEn = 1'b0;
    cyc(0, 0, 0, 0, 1, 3, 0);
    chk("ar_read_vld", rdValid, 1);
    chk("ar_read_data", outputData, 0);
    chk("ar_read_ce", correctableError, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
